// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode/execute front end: fetches one instruction word, decodes it
// for the ALU/register file and updates the PC. Optional FETCH_NUM_INST_EN adds a retired-instruction counter.
module fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_inputReady,
  output logic [3:0]  alu_opcode,
  output logic [5:0]  alu_func,
  output logic [15:0] imm_ext,
  output logic        use_imm,
  output logic [1:0]  rs_idx,
  output logic [1:0]  rt_idx,
  output logic [1:0]  rd_idx,
  output logic        reg_we,
  output logic        wwd_valid
`ifdef FETCH_NUM_INST_EN
  ,
  output logic [15:0] num_inst
`endif
);

  localparam logic [3:0] OP_ADI    = 4'd4;
  localparam logic [3:0] OP_LHI    = 4'd6;
  localparam logic [3:0] OP_JMP    = 4'd9;
  localparam logic [3:0] OP_RTYPE  = 4'd15;
  localparam logic [5:0] FUNC_ADD  = 6'd0;
  localparam logic [5:0] FUNC_WWD  = 6'd28;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        w_ir_load;
  logic        w_pc_upd;
  logic [15:0] w_pc_nxt;

  logic [3:0]  w_op;
  logic [5:0]  w_func;
  logic        w_is_adi;
  logic        w_is_lhi;
  logic        w_is_jmp;
  logic        w_is_rtype;
  logic        w_is_add;
  logic        w_is_wwd;
  logic [15:0] w_imm;
  logic [1:0]  w_rd;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_pc_upd    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (i_inputReady) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_pc_upd    = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // PC and instruction register; reset abandons any pending fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_ir <= 16'h0000;
    end else begin
      if (w_ir_load) r_ir <= i_data;
      if (w_pc_upd)  r_pc <= w_pc_nxt;
    end
  end

`ifdef FETCH_NUM_INST_EN
  logic [15:0] r_num_inst;

  // Every execute cycle retires one instruction, NOPs included
  always_ff @(posedge clk) begin
    if (reset)                 r_num_inst <= 16'h0000;
    else if (r_state == S_EXEC) r_num_inst <= r_num_inst + 16'd1;
  end

  assign num_inst = reset ? 16'h0000 : r_num_inst;
`endif

  assign w_op       = r_ir[15:12];
  assign w_func     = r_ir[5:0];
  assign w_is_adi   = (w_op == OP_ADI);
  assign w_is_lhi   = (w_op == OP_LHI);
  assign w_is_jmp   = (w_op == OP_JMP);
  assign w_is_rtype = (w_op == OP_RTYPE);
  assign w_is_add   = w_is_rtype && (w_func == FUNC_ADD);
  assign w_is_wwd   = w_is_rtype && (w_func == FUNC_WWD);

  assign w_imm = w_is_adi ? {{8{r_ir[7]}}, r_ir[7:0]} :
                 w_is_lhi ? {8'h00, r_ir[7:0]}       : 16'h0000;
  assign w_rd  = w_is_rtype              ? r_ir[7:6] :
                 (w_is_adi || w_is_lhi)  ? r_ir[9:8] : 2'd0;

  assign w_pc_nxt = w_is_jmp ? {r_pc[15:12], r_ir[11:0]} : r_pc + 16'd1;

  // Outputs are forced to their idle values for as long as reset is held
  assign i_readM    = !reset && (r_state == S_FETCH);
  assign i_address  = reset ? RESET_PC : r_pc;
  assign alu_opcode = reset ? 4'd0 : w_op;
  assign alu_func   = reset ? 6'd0 : w_func;
  assign imm_ext    = reset ? 16'h0000 : w_imm;
  assign use_imm    = !reset && (w_is_adi || w_is_lhi);
  assign rs_idx     = reset ? 2'd0 : r_ir[11:10];
  assign rt_idx     = reset ? 2'd0 : r_ir[9:8];
  assign rd_idx     = reset ? 2'd0 : w_rd;
  assign reg_we     = !reset && (r_state == S_EXEC) && (w_is_add || w_is_adi || w_is_lhi);
  assign wwd_valid  = !reset && (r_state == S_EXEC) && w_is_wwd;

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized bench for fetch_decode against an instruction-level reference model.
// Define FETCH_NUM_INST_EN on both files to also cover the retired-instruction counter.
module tb_fetch_decode;

  localparam logic [15:0] TB_RESET_PC = 16'h0000;

  logic        clk;
  logic        reset;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_inputReady;
  logic [3:0]  alu_opcode;
  logic [5:0]  alu_func;
  logic [15:0] imm_ext;
  logic        use_imm;
  logic [1:0]  rs_idx;
  logic [1:0]  rt_idx;
  logic [1:0]  rd_idx;
  logic        reg_we;
  logic        wwd_valid;
`ifdef FETCH_NUM_INST_EN
  logic [15:0] num_inst;
`endif

  fetch_decode #(.RESET_PC(TB_RESET_PC)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_readM      (i_readM),
    .i_address    (i_address),
    .i_data       (i_data),
    .i_inputReady (i_inputReady),
    .alu_opcode   (alu_opcode),
    .alu_func     (alu_func),
    .imm_ext      (imm_ext),
    .use_imm      (use_imm),
    .rs_idx       (rs_idx),
    .rt_idx       (rt_idx),
    .rd_idx       (rd_idx),
    .reg_we       (reg_we),
    .wwd_valid    (wwd_valid)
`ifdef FETCH_NUM_INST_EN
    ,
    .num_inst     (num_inst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [15:0] m_pc;
  logic [15:0] m_count;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_readM"}, 16'(i_readM), 16'd0);
    check({tag, "_addr"},  i_address, TB_RESET_PC);
    check({tag, "_op"},    16'(alu_opcode), 16'd0);
    check({tag, "_func"},  16'(alu_func), 16'd0);
    check({tag, "_imm"},   imm_ext, 16'd0);
    check({tag, "_useimm"}, 16'(use_imm), 16'd0);
    check({tag, "_idx"},   16'({rs_idx, rt_idx, rd_idx}), 16'd0);
    check({tag, "_we"},    16'(reg_we), 16'd0);
    check({tag, "_wwd"},   16'(wwd_valid), 16'd0);
`ifdef FETCH_NUM_INST_EN
    check({tag, "_num"},   num_inst, 16'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check_idle("rst");
    step();
    check_idle("rst2");
    reset = 1'b0;
    i_inputReady = 1'b0;
    m_pc = TB_RESET_PC;
    m_count = 16'd0;
    #1;
    check("rst_release_readM", 16'(i_readM), 16'd1);
    check("rst_release_addr", i_address, TB_RESET_PC);
  endtask

  // One full instruction: fetch with dly wait cycles, decode, execute
  task automatic run_instr(input logic [15:0] instr, input int unsigned dly);
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [15:0] e_imm;
    logic [1:0]  e_rd;
    logic        e_use, e_we, e_wwd;
    op = instr[15:12];
    fn = instr[5:0];
    e_use = (op == 4'd4) || (op == 4'd6);
    if (op == 4'd4)      e_imm = instr[7] ? 16'(instr[7:0]) + 16'hFF00 : 16'(instr[7:0]);
    else if (op == 4'd6) e_imm = 16'(instr[7:0]);
    else                 e_imm = 16'd0;
    if (op == 4'd15) e_rd = instr[7:6];
    else if (e_use)  e_rd = instr[9:8];
    else             e_rd = 2'd0;
    e_wwd = (op == 4'd15) && (fn == 6'd28);
    e_we  = e_use || ((op == 4'd15) && (fn == 6'd0));

    for (int k = 0; k <= int'(dly); k++) begin
      check("fetch_readM", 16'(i_readM), 16'd1);
      check("fetch_addr", i_address, m_pc);
      check("fetch_we", 16'({reg_we, wwd_valid}), 16'd0);
`ifdef FETCH_NUM_INST_EN
      check("fetch_num", num_inst, m_count);
`endif
      i_inputReady = (k == int'(dly));
      i_data = (k == int'(dly)) ? instr : 16'($urandom);
      step();
    end
    // Strobes outside fetch must be ignored
    i_inputReady = 1'($urandom);
    i_data = 16'($urandom);
    check("dec_readM", 16'(i_readM), 16'd0);
    check("dec_op", 16'(alu_opcode), 16'(op));
    check("dec_func", 16'(alu_func), 16'(fn));
    check("dec_imm", imm_ext, e_imm);
    check("dec_useimm", 16'(use_imm), 16'(e_use));
    check("dec_rs", 16'(rs_idx), 16'(instr[11:10]));
    check("dec_rt", 16'(rt_idx), 16'(instr[9:8]));
    check("dec_rd", 16'(rd_idx), 16'(e_rd));
    check("dec_pulses", 16'({reg_we, wwd_valid}), 16'd0);
    step();
    i_inputReady = 1'($urandom);
    check("exe_readM", 16'(i_readM), 16'd0);
    check("exe_we", 16'(reg_we), 16'(e_we));
    check("exe_wwd", 16'(wwd_valid), 16'(e_wwd));
    check("exe_imm", imm_ext, e_imm);
    check("exe_rd", 16'(rd_idx), 16'(e_rd));
    step();
    i_inputReady = 1'b0;
    if (op == 4'd9) m_pc = (m_pc & 16'hF000) | (instr & 16'h0FFF);
    else            m_pc = m_pc + 16'd1;
    m_count = m_count + 16'd1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 6))
      0: return {4'd4, r[11:0]};
      1: return {4'd6, r[11:0]};
      2: return {4'd9, r[11:0]};
      3: return {4'd15, r[11:6], 6'd0};
      4: return {4'd15, r[11:6], 6'd28};
      5: return {4'd15, r[11:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    i_inputReady = 1'b0;
    i_data = 16'h0000;
    @(negedge clk);
    do_reset();

    run_instr(16'h4405, 0);
    check("adi_next_addr", i_address, 16'h0001);
    run_instr(16'h44FE, 1);
    run_instr(16'h61AB, 0);
    run_instr(16'hF01C, 2);
    run_instr(16'hF0C0, 0);
    run_instr(16'h2123, 0);
    run_instr(16'h4777, 4);

    // Climb the PC nibble by nibble with JMP + NOP to reach 0x3010
    while (m_pc[15:12] != 4'h3) begin
      run_instr(16'h9FFF, 0);
      run_instr(16'h2000, 0);
    end
    run_instr(16'h9010, 0);
    check("pc_3010", i_address, 16'h3010);
    run_instr(16'h9123, 1);
    check("jmp_3123", i_address, 16'h3123);

    while (m_pc[15:12] != 4'hF) begin
      run_instr(16'h9FFF, 0);
      run_instr(16'h2000, 0);
    end
    run_instr(16'h9FFF, 0);
    check("pc_ffff", i_address, 16'hFFFF);
    run_instr(16'hF0C0, 0);
    check("pc_wrap", i_address, 16'h0000);

    // Reset while a fetch is waiting, with a strobe presented at the same edge
    run_instr(16'h4001, 0);
    i_inputReady = 1'b0;
    step();
    step();
    check("wait_readM", 16'(i_readM), 16'd1);
    check("wait_addr", i_address, m_pc);
    reset = 1'b1;
    i_inputReady = 1'b1;
    i_data = 16'h9FFF;
    step();
    check_idle("midrst");
    i_inputReady = 1'b0;
    reset = 1'b0;
    m_pc = TB_RESET_PC;
    m_count = 16'd0;
    #1;
    check("midrst_readM", 16'(i_readM), 16'd1);
    check("midrst_addr", i_address, TB_RESET_PC);
    @(negedge clk);

    run_instr(16'h4405, 0);
    run_instr(16'h2222, 1);
    run_instr(16'hF01C, 0);
`ifdef FETCH_NUM_INST_EN
    check("num_three", num_inst, 16'd3);
`endif
    check("three_addr", i_address, 16'h0003);

    for (int n = 0; n < 150; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 3));
    end

    do_reset();
    run_instr(rand_instr(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
